// File: rtl/mppt_pwm_pkg.sv
// Shared types and helpers for the MPPT gate-drive PWM generator.
// State encoding, duty width, duty clamp and duty-to-compare scaling.
package mppt_pwm_pkg;

  localparam int DUTY_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pwm_state_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] d,
    input logic [DUTY_W-1:0] lo,
    input logic [DUTY_W-1:0] hi
  );
    if (d < lo) return lo;
    else if (d > hi) return hi;
    else return d;
  endfunction

  // Duty is a fraction d/65536 of the period; the product fits in 32 bits.
  function automatic logic [31:0] duty_to_cmp(
    input logic [DUTY_W-1:0] d,
    input logic [31:0]       period
  );
    logic [31:0] prod;
    prod = {16'b0, d} * period;
    return prod >> 16;
  endfunction

endpackage

// File: rtl/mppt_pwm_slew.sv
// Duty capture, clamp and boundary update of the applied duty.
// MPPT_PWM_SOFTSTART_EN enables soft-start: restart from DUTY_MIN and slew-limited steps.
module mppt_pwm_slew import mppt_pwm_pkg::*; #(
  parameter logic [DUTY_W-1:0] DUTY_MIN  = 16'h0800,
  parameter logic [DUTY_W-1:0] DUTY_MAX  = 16'hF000,
  parameter logic [DUTY_W-1:0] SLEW_STEP = 16'h0100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] duty_cycle,
  input  logic              duty_valid,
  input  logic              start,
  input  logic              load,
  output logic [DUTY_W-1:0] applied_duty,
  output logic [DUTY_W-1:0] applied_next,
  output logic              ack_next
);

`ifdef MPPT_PWM_SOFTSTART_EN
  localparam bit SOFTSTART = 1'b1;
`else
  localparam bit SOFTSTART = 1'b0;
`endif

  logic [DUTY_W-1:0] pending;
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] stepped;

  // A strobe in the boundary cycle bypasses pending and is applied right away.
  assign target = duty_valid ? clamp_duty(duty_cycle, DUTY_MIN, DUTY_MAX) : pending;

  always_comb begin
    stepped = target;
    if (target > applied_duty) begin
      if (target - applied_duty > SLEW_STEP) stepped = applied_duty + SLEW_STEP;
    end else if (applied_duty - target > SLEW_STEP) begin
      stepped = applied_duty - SLEW_STEP;
    end
  end

  always_comb begin
    applied_next = applied_duty;
    ack_next     = 1'b0;
    if (start) begin
      applied_next = SOFTSTART ? DUTY_MIN : applied_duty;
    end else if (load) begin
      applied_next = SOFTSTART ? stepped : target;
      ack_next     = (applied_next != applied_duty) &&
                     (!SOFTSTART || (applied_next == target));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= DUTY_MIN;
      applied_duty <= DUTY_MIN;
    end else begin
      if (duty_valid) pending <= target;
      applied_duty <= applied_next;
    end
  end

endmodule

// File: rtl/mppt_pwm_gen.sv
// Complementary PWM with dead-time, period-boundary duty update and latched fault.
// Optional soft-start is selected with MPPT_PWM_SOFTSTART_EN (see mppt_pwm_slew).
module mppt_pwm_gen import mppt_pwm_pkg::*; #(
  parameter int                PERIOD    = 1000,
  parameter int                CNT_W     = 16,
  parameter int                DEAD      = 4,
  parameter logic [DUTY_W-1:0] DUTY_MIN  = 16'h0800,
  parameter logic [DUTY_W-1:0] DUTY_MAX  = 16'hF000,
  parameter logic [DUTY_W-1:0] SLEW_STEP = 16'h0100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_cycle,
  input  logic              duty_valid,
  input  logic              fault_in,
  input  logic              fault_clear,
  output logic              pwm_hi,
  output logic              pwm_lo,
  output logic              period_start,
  output logic              duty_ack,
  output logic [DUTY_W-1:0] applied_duty,
  output logic              fault_latched,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD);

  pwm_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, cmp;
  logic [CNT_W:0]    lo_thresh;
  logic              go, start, load, hi_c, lo_c, ack_next;
  logic [DUTY_W-1:0] applied_next;

  // Handshake: duty_valid is a one-cycle strobe with no back-pressure (always
  // accepted, last wins); duty_ack is a one-cycle strobe at cnt==0 when the
  // pending value took effect and changed the applied duty.
  mppt_pwm_slew #(
    .DUTY_MIN (DUTY_MIN),
    .DUTY_MAX (DUTY_MAX),
    .SLEW_STEP(SLEW_STEP)
  ) u_slew (
    .clk         (clk),
    .reset       (reset),
    .duty_cycle  (duty_cycle),
    .duty_valid  (duty_valid),
    .start       (start),
    .load        (load),
    .applied_duty(applied_duty),
    .applied_next(applied_next),
    .ack_next    (ack_next)
  );

  assign go        = (state == RUN) && enable && !fault_in;
  assign start     = (state == IDLE) && enable && !fault_in;
  assign load      = go && (cnt == LAST);
  assign lo_thresh = {1'b0, cmp} + (CNT_W + 1)'(DEAD);
  assign hi_c      = (cnt >= DEAD_C) && (cnt < cmp);
  assign lo_c      = {1'b0, cnt} >= lo_thresh;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
      end
      FAULT: begin
        cnt_next = '0;
        if (fault_clear) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // Fault wins over everything, including a clear in the same cycle.
    if (fault_in) begin
      state_next = FAULT;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      cmp           <= '0;
      pwm_hi        <= 1'b0;
      pwm_lo        <= 1'b0;
      period_start  <= 1'b0;
      duty_ack      <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      if (start || load) cmp <= CNT_W'(duty_to_cmp(applied_next, 32'(PERIOD)));
      pwm_hi        <= go && hi_c;
      pwm_lo        <= go && lo_c;
      period_start  <= (state_next == RUN) && (cnt_next == '0);
      duty_ack      <= load && ack_next;
      fault_latched <= (state_next == FAULT);
    end
  end

  gate_exclusive: assert property (@(posedge clk) disable iff (reset) !(pwm_hi && pwm_lo));

endmodule

// File: tb/tb_mppt_pwm_gen.sv
// Self-checking bench for mppt_pwm_gen: vector table, corner sequences and a
// randomized run against a cycle-level behavioural model.
module tb_mppt_pwm_gen;

  localparam int          PERIOD = 100;
  localparam int          DEAD   = 2;
  localparam logic [15:0] DMIN   = 16'h0000;
  localparam logic [15:0] DMAX   = 16'hF000;
  localparam logic [15:0] STEP   = 16'h1000;
  localparam int          W      = 23;
`ifdef MPPT_PWM_SOFTSTART_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, duty_valid, fault_in, fault_clear;
  logic [15:0] duty_cycle;
  logic        pwm_hi, pwm_lo, period_start, duty_ack, fault_latched;
  logic [15:0] applied_duty;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mppt_pwm_gen #(
    .PERIOD(PERIOD), .CNT_W(16), .DEAD(DEAD),
    .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .SLEW_STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .duty_cycle(duty_cycle), .duty_valid(duty_valid),
    .fault_in(fault_in), .fault_clear(fault_clear),
    .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .period_start(period_start),
    .duty_ack(duty_ack), .applied_duty(applied_duty),
    .fault_latched(fault_latched), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  int m_state, m_cnt, m_cmp, m_pend, m_app;
  bit m_hi, m_lo, m_ps, m_ack;
  logic [W-1:0] exp_q[$];

  function automatic int clampv(int d);
    if (d < int'(DMIN)) return int'(DMIN);
    if (d > int'(DMAX)) return int'(DMAX);
    return d;
  endfunction

  function automatic int cmp_of(int d);
    return int'((longint'(d) * PERIOD) / 65536);
  endfunction

  function automatic int slew_toward(int a, int t);
    if (t > a) return (t - a > int'(STEP)) ? a + int'(STEP) : t;
    return (a - t > int'(STEP)) ? a - int'(STEP) : t;
  endfunction

  task automatic model_step();
    int req, nxt;
    req   = duty_valid ? clampv(int'(duty_cycle)) : m_pend;
    m_hi  = 0;
    m_lo  = 0;
    m_ack = 0;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_cmp = 0;
      m_pend  = int'(DMIN); m_app = int'(DMIN);
    end else begin
      m_pend = req;
      if (fault_in) begin
        m_state = 2; m_cnt = 0;
      end else if (m_state == 0) begin
        if (enable) begin
          m_state = 1; m_cnt = 0;
          if (SOFT) m_app = int'(DMIN);
          m_cmp = cmp_of(m_app);
        end
      end else if (m_state == 2) begin
        if (fault_clear) m_state = 0;
      end else if (!enable) begin
        m_state = 0; m_cnt = 0;
      end else begin
        m_hi = (m_cnt >= DEAD) && (m_cnt < m_cmp);
        m_lo = (m_cnt >= m_cmp + DEAD);
        if (m_cnt == PERIOD - 1) begin
          nxt   = SOFT ? slew_toward(m_app, req) : req;
          m_ack = (nxt != m_app) && (!SOFT || nxt == req);
          m_app = nxt;
          m_cmp = cmp_of(nxt);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    m_ps = (m_state == 1) && (m_cnt == 0);
    exp_q.push_back({m_state[1:0], m_hi, m_lo, m_ps, m_ack, (m_state == 2), m_app[15:0]});
  endtask

  // ---------------- driver / scoreboard ----------------
  task automatic tick();
    logic [W-1:0] act, exp;
    @(posedge clk);
    model_step();
    #1;
    act = {dbg_state, pwm_hi, pwm_lo, period_start, duty_ack, fault_latched, applied_duty};
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act, exp);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_start();
    int guard;
    guard = 0;
    while (period_start !== 1'b1 && guard < 3 * PERIOD) begin
      tick();
      guard++;
    end
    check("period_start_timeout", int'(period_start === 1'b1), 1);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (pwm_hi === 1'b1 && pwm_lo === 1'b1) begin
        errors++;
        $display("FAIL gate_overlap t=%0t actual=hi1_lo1 required=not_both", $time);
      end
    end
  end

  typedef struct {
    logic [15:0] duty;
    bit          late;
    logic [15:0] app;
    bit          ack;
    int          hi_w;
    int          lo_w;
  } vec_t;

  vec_t vecs[7];
  logic [16:0] ss_q[$];

  initial begin
    vecs[0] = '{16'h8000, 1'b0, 16'h8000, 1'b1, 48, 48};
    vecs[1] = '{16'h4000, 1'b1, 16'h4000, 1'b1, 23, 73};
    vecs[2] = '{16'hFFFF, 1'b0, 16'hF000, 1'b1, 91, 5};
    vecs[3] = '{16'h0200, 1'b0, 16'h0200, 1'b1, 0, 98};
    vecs[4] = '{16'h0200, 1'b1, 16'h0200, 1'b0, 0, 98};
    vecs[5] = '{16'h1000, 1'b0, 16'h1000, 1'b1, 4, 92};
    vecs[6] = '{16'h0000, 1'b0, 16'h0000, 1'b1, 0, 98};

    reset = 1'b1; enable = 1'b0; duty_valid = 1'b0; duty_cycle = '0;
    fault_in = 1'b0; fault_clear = 1'b0;
    tick(); tick();
    check("reset_applied", int'(applied_duty), int'(DMIN));
    check("reset_gates", int'({pwm_hi, pwm_lo, period_start, duty_ack, fault_latched}), 0);
    reset = 1'b0; tick();
    enable = 1'b1; tick();
    check("enter_run_start", int'(period_start), 1);

`ifndef MPPT_PWM_SOFTSTART_EN
    for (int i = 0; i < 7; i++) begin
      int hi_n, lo_n;
      if (vecs[i].late) repeat (PERIOD - 1) tick();
      duty_cycle = vecs[i].duty; duty_valid = 1'b1; tick(); duty_valid = 1'b0;
      wait_start();
      check("vec_applied", int'(applied_duty), int'(vecs[i].app));
      check("vec_ack", int'(duty_ack), int'(vecs[i].ack));
      hi_n = 0; lo_n = 0;
      repeat (PERIOD) begin
        tick();
        hi_n += int'(pwm_hi);
        lo_n += int'(pwm_lo);
      end
      check("vec_hi_width", hi_n, vecs[i].hi_w);
      check("vec_lo_width", lo_n, vecs[i].lo_w);
    end
`else
    for (int k = 1; k <= 8; k++) begin
      int v;
      v = (k * int'(STEP) > 32'h8000) ? 32'h8000 : k * int'(STEP);
      ss_q.push_back({(k == 8), v[15:0]});
    end
    duty_cycle = 16'h8000; duty_valid = 1'b1; tick(); duty_valid = 1'b0;
    while (ss_q.size() > 0) begin
      logic [16:0] e;
      e = ss_q.pop_front();
      wait_start();
      check("soft_applied", int'(applied_duty), int'(e[15:0]));
      check("soft_ack", int'(duty_ack), int'(e[16]));
      tick();
    end
`endif

    // Fault while the high-side gate is on.
    begin
      int guard;
      duty_cycle = 16'h8000; duty_valid = 1'b1; tick(); duty_valid = 1'b0;
      guard = 0;
      while (pwm_hi !== 1'b1 && guard < 10 * PERIOD) begin tick(); guard++; end
      check("fault_pre_hi", int'(pwm_hi === 1'b1), 1);
    end
    fault_in = 1'b1; tick();
    check("fault_gates_low", int'({pwm_hi, pwm_lo}), 0);
    check("fault_latched", int'(fault_latched), 1);
    fault_clear = 1'b1; tick(); fault_clear = 1'b0;
    check("fault_clear_ignored", int'(fault_latched), 1);
    fault_in = 1'b0; repeat (3) tick();
    check("fault_held", int'(dbg_state), 2);
    fault_clear = 1'b1; tick(); fault_clear = 1'b0;
    check("fault_exit_idle", int'(dbg_state), 0);
    check("fault_exit_unlatched", int'(fault_latched), 0);
    tick();
    check("fault_rerun", int'(dbg_state), 1);

    // Enable drop and reset in the middle of a period.
    repeat (60) tick();
    enable = 1'b0; tick();
    check("disable_gates", int'({pwm_hi, pwm_lo, period_start}), 0);
    check("disable_idle", int'(dbg_state), 0);
    enable = 1'b1; tick();
    check("reenable_start", int'(period_start), 1);
    repeat (37) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("midreset_gates", int'({pwm_hi, pwm_lo}), 0);
    check("midreset_applied", int'(applied_duty), int'(DMIN));

    // Randomized run against the model.
    repeat (4000) begin
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      duty_valid  = ($urandom_range(0, 19) == 0);
      duty_cycle  = 16'($urandom);
      fault_in    = ($urandom_range(0, 299) == 0) || (fault_in && $urandom_range(0, 3) != 0);
      fault_clear = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0; duty_valid = 1'b0; fault_in = 1'b0; fault_clear = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
